// File: rtl/estagio_decodificacao_pkg.sv
// MIPS decode constants and the control/ID-EX payloads shared with the execute stage.
package pacote_mips;

  localparam int unsigned LARGURA_DADO = 32;
  localparam int unsigned LARGURA_END  = 5;
  localparam int unsigned LARGURA_ULA  = 4;
  localparam int unsigned LARGURA_OP   = 6;

  localparam logic [LARGURA_OP-1:0] OP_TIPO_R = 6'h00;
  localparam logic [LARGURA_OP-1:0] OP_BEQ    = 6'h04;
  localparam logic [LARGURA_OP-1:0] OP_ADDI   = 6'h08;
  localparam logic [LARGURA_OP-1:0] OP_SLTI   = 6'h0A;
  localparam logic [LARGURA_OP-1:0] OP_ANDI   = 6'h0C;
  localparam logic [LARGURA_OP-1:0] OP_ORI    = 6'h0D;
  localparam logic [LARGURA_OP-1:0] OP_LUI    = 6'h0F;
  localparam logic [LARGURA_OP-1:0] OP_LW     = 6'h23;
  localparam logic [LARGURA_OP-1:0] OP_SW     = 6'h2B;

  localparam logic [LARGURA_OP-1:0] FN_ADD = 6'h20;
  localparam logic [LARGURA_OP-1:0] FN_SUB = 6'h22;
  localparam logic [LARGURA_OP-1:0] FN_AND = 6'h24;
  localparam logic [LARGURA_OP-1:0] FN_OR  = 6'h25;
  localparam logic [LARGURA_OP-1:0] FN_SLT = 6'h2A;

  typedef enum logic [LARGURA_ULA-1:0] {
    ULA_ADD     = 4'd0,
    ULA_SUB     = 4'd1,
    ULA_AND     = 4'd2,
    ULA_OR      = 4'd3,
    ULA_SLT     = 4'd4,
    ULA_PASSA_B = 4'd5
  } ula_op_t;

  typedef enum logic [1:0] {
    IMM_SINAL = 2'd0,
    IMM_ZERO  = 2'd1,
    IMM_ALTO  = 2'd2
  } tipo_imediato_t;

  typedef struct packed {
    logic    reg_escrita;
    logic    mem_leitura;
    logic    mem_escrita;
    logic    mem_para_reg;
    logic    ula_fonte;
    ula_op_t ula_op;
  } controle_t;

  typedef struct packed {
    logic                    valido;
    controle_t               controle;
    logic                    excecao;
    logic [LARGURA_DADO-1:0] dado_rs;
    logic [LARGURA_DADO-1:0] dado_rt;
    logic [LARGURA_DADO-1:0] imediato;
    logic [LARGURA_DADO-1:0] pc_mais4;
    logic [LARGURA_END-1:0]  rs;
    logic [LARGURA_END-1:0]  rt;
    logic [LARGURA_END-1:0]  destino;
  } id_ex_t;

endpackage

// File: rtl/estagio_decodificacao_if.sv
// Read port between the decode stage (master) and the register bank (slave).
interface estagio_decodificacao_if;

  logic [pacote_mips::LARGURA_END-1:0]  endereco_leitura_1;
  logic [pacote_mips::LARGURA_END-1:0]  endereco_leitura_2;
  logic [pacote_mips::LARGURA_DADO-1:0] dado_leitura_1;
  logic [pacote_mips::LARGURA_DADO-1:0] dado_leitura_2;

  modport master (
    output endereco_leitura_1, endereco_leitura_2,
    input  dado_leitura_1, dado_leitura_2
  );

  modport slave (
    input  endereco_leitura_1, endereco_leitura_2,
    output dado_leitura_1, dado_leitura_2
  );

endinterface

// File: rtl/estagio_decodificacao_unidade_controle.sv
// Combinational opcode/funct decoder; unknown encodings flag an exception with all writes off.
module unidade_controle
  import pacote_mips::*;
(
  input  logic [LARGURA_OP-1:0] opcode_i,
  input  logic [LARGURA_OP-1:0] funct_i,
  output controle_t             controle_c_o,
  output tipo_imediato_t        tipo_imediato_c_o,
  output logic                  destino_rd_c_o,
  output logic                  rt_fonte_c_o,
  output logic                  excecao_c_o
);

  always_comb begin
    controle_c_o        = '0;
    controle_c_o.ula_op = ULA_ADD;
    tipo_imediato_c_o   = IMM_SINAL;
    destino_rd_c_o      = 1'b0;
    rt_fonte_c_o        = 1'b0;
    excecao_c_o         = 1'b0;

    case (opcode_i)
      OP_TIPO_R: begin
        destino_rd_c_o           = 1'b1;
        rt_fonte_c_o             = 1'b1;
        controle_c_o.reg_escrita = 1'b1;
        case (funct_i)
          FN_ADD:  controle_c_o.ula_op = ULA_ADD;
          FN_SUB:  controle_c_o.ula_op = ULA_SUB;
          FN_AND:  controle_c_o.ula_op = ULA_AND;
          FN_OR:   controle_c_o.ula_op = ULA_OR;
          FN_SLT:  controle_c_o.ula_op = ULA_SLT;
          default: begin
            controle_c_o.reg_escrita = 1'b0;
            excecao_c_o              = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        controle_c_o.reg_escrita = 1'b1;
        controle_c_o.ula_fonte   = 1'b1;
        controle_c_o.ula_op      = (opcode_i == OP_SLTI) ? ULA_SLT : ULA_ADD;
      end
      OP_ANDI, OP_ORI: begin
        controle_c_o.reg_escrita = 1'b1;
        controle_c_o.ula_fonte   = 1'b1;
        controle_c_o.ula_op      = (opcode_i == OP_ORI) ? ULA_OR : ULA_AND;
        tipo_imediato_c_o        = IMM_ZERO;
      end
      OP_LUI: begin
        controle_c_o.reg_escrita = 1'b1;
        controle_c_o.ula_fonte   = 1'b1;
        controle_c_o.ula_op      = ULA_PASSA_B;
        tipo_imediato_c_o        = IMM_ALTO;
      end
      OP_LW: begin
        controle_c_o.reg_escrita  = 1'b1;
        controle_c_o.ula_fonte    = 1'b1;
        controle_c_o.mem_leitura  = 1'b1;
        controle_c_o.mem_para_reg = 1'b1;
      end
      OP_SW: begin
        controle_c_o.ula_fonte   = 1'b1;
        controle_c_o.mem_escrita = 1'b1;
        rt_fonte_c_o             = 1'b1;
      end
      OP_BEQ: begin
        controle_c_o.ula_op = ULA_SUB;
        rt_fonte_c_o        = 1'b1;
      end
      default: excecao_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/estagio_decodificacao.sv
// MIPS ID stage: bank addressing, WB bypass, load-use stall and the ID/EX register.
module estagio_decodificacao
  import pacote_mips::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [LARGURA_DADO-1:0] instrucao,
  input  logic                    instr_valida,
  input  logic [LARGURA_DADO-1:0] pc_mais4,
  input  logic                    descarte,
  estagio_decodificacao_if.master banco,
  input  logic                    uc_escrita_wb,
  input  logic [LARGURA_END-1:0]  endereco_escrita_wb,
  input  logic [LARGURA_DADO-1:0] dado_escrita_wb,
  output logic                    parar_if,
  output logic                    ex_valido,
  output logic                    ex_reg_escrita,
  output logic                    ex_mem_leitura,
  output logic                    ex_mem_escrita,
  output logic                    ex_mem_para_reg,
  output logic                    ex_ula_fonte,
  output logic                    ex_excecao,
  output logic [LARGURA_ULA-1:0]  ex_ula_op,
  output logic [LARGURA_DADO-1:0] ex_dado_rs,
  output logic [LARGURA_DADO-1:0] ex_dado_rt,
  output logic [LARGURA_DADO-1:0] ex_imediato,
  output logic [LARGURA_DADO-1:0] ex_pc_mais4,
  output logic [LARGURA_END-1:0]  ex_rs,
  output logic [LARGURA_END-1:0]  ex_rt,
  output logic [LARGURA_END-1:0]  ex_destino
);

  logic [LARGURA_END-1:0] rs, rt, rd;
  logic [15:0]            imm;
  controle_t              controle;
  tipo_imediato_t         tipo_imediato;
  logic                   destino_rd, rt_fonte, excecao;
  logic                   risco_c, carrega_c;
  id_ex_t                 id_ex_d, id_ex_q;

  assign rs  = instrucao[25:21];
  assign rt  = instrucao[20:16];
  assign rd  = instrucao[15:11];
  assign imm = instrucao[15:0];

  assign banco.endereco_leitura_1 = rs;
  assign banco.endereco_leitura_2 = rt;

  unidade_controle u_controle (
    .opcode_i          (instrucao[31:26]),
    .funct_i           (instrucao[5:0]),
    .controle_c_o      (controle),
    .tipo_imediato_c_o (tipo_imediato),
    .destino_rd_c_o    (destino_rd),
    .rt_fonte_c_o      (rt_fonte),
    .excecao_c_o       (excecao)
  );

  // The bank commits WB writes late, so a same-cycle WB value must win over the bank read.
  function automatic logic [LARGURA_DADO-1:0] operando(
    input logic [LARGURA_END-1:0]  endereco,
    input logic [LARGURA_DADO-1:0] dado_banco,
    input logic                    escrita_wb,
    input logic [LARGURA_END-1:0]  endereco_wb,
    input logic [LARGURA_DADO-1:0] dado_wb
  );
    if (endereco == '0)                            return '0;
    else if (escrita_wb && endereco_wb == endereco) return dado_wb;
    else                                           return dado_banco;
  endfunction

  // Load in EX whose destination feeds this instruction: hold IF for one bubble.
  assign risco_c = id_ex_q.valido & id_ex_q.controle.mem_leitura & (id_ex_q.destino != '0)
                 & instr_valida
                 & ((id_ex_q.destino == rs) | (rt_fonte & (id_ex_q.destino == rt)));

  assign parar_if  = risco_c & ~descarte;
  assign carrega_c = instr_valida & ~descarte & ~risco_c;

  always_comb begin
    id_ex_d = '0;
    if (carrega_c) begin
      id_ex_d.valido   = 1'b1;
      id_ex_d.controle = controle;
      id_ex_d.excecao  = excecao;
      id_ex_d.dado_rs  = operando(rs, banco.dado_leitura_1, uc_escrita_wb,
                                  endereco_escrita_wb, dado_escrita_wb);
      id_ex_d.dado_rt  = operando(rt, banco.dado_leitura_2, uc_escrita_wb,
                                  endereco_escrita_wb, dado_escrita_wb);
      id_ex_d.pc_mais4 = pc_mais4;
      id_ex_d.rs       = rs;
      id_ex_d.rt       = rt;
      id_ex_d.destino  = destino_rd ? rd : rt;
      if (id_ex_d.destino == '0) id_ex_d.controle.reg_escrita = 1'b0;
      case (tipo_imediato)
        IMM_ZERO: id_ex_d.imediato = {16'h0000, imm};
        IMM_ALTO: id_ex_d.imediato = {imm, 16'h0000};
        default:  id_ex_d.imediato = {{16{imm[15]}}, imm};
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) id_ex_q <= '0;
    else          id_ex_q <= id_ex_d;
  end

  assign ex_valido       = id_ex_q.valido;
  assign ex_reg_escrita  = id_ex_q.controle.reg_escrita;
  assign ex_mem_leitura  = id_ex_q.controle.mem_leitura;
  assign ex_mem_escrita  = id_ex_q.controle.mem_escrita;
  assign ex_mem_para_reg = id_ex_q.controle.mem_para_reg;
  assign ex_ula_fonte    = id_ex_q.controle.ula_fonte;
  assign ex_ula_op       = id_ex_q.controle.ula_op;
  assign ex_excecao      = id_ex_q.excecao;
  assign ex_dado_rs      = id_ex_q.dado_rs;
  assign ex_dado_rt      = id_ex_q.dado_rt;
  assign ex_imediato     = id_ex_q.imediato;
  assign ex_pc_mais4     = id_ex_q.pc_mais4;
  assign ex_rs           = id_ex_q.rs;
  assign ex_rt           = id_ex_q.rt;
  assign ex_destino      = id_ex_q.destino;

endmodule

// File: tb/tb_estagio_decodificacao.sv
// Self-checking bench for estagio_decodificacao: directed scenarios plus random traffic vs. a reference model.
module tb_estagio_decodificacao;

  logic        clock, reset_n;
  logic [31:0] instrucao, pc_mais4, dado_escrita_wb;
  logic        instr_valida, descarte, uc_escrita_wb;
  logic [4:0]  endereco_escrita_wb;
  logic        parar_if, ex_valido, ex_reg_escrita, ex_mem_leitura, ex_mem_escrita;
  logic        ex_mem_para_reg, ex_ula_fonte, ex_excecao;
  logic [3:0]  ex_ula_op;
  logic [31:0] ex_dado_rs, ex_dado_rt, ex_imediato, ex_pc_mais4;
  logic [4:0]  ex_rs, ex_rt, ex_destino;

  estagio_decodificacao_if banco ();

  estagio_decodificacao dut (
    .clock(clock), .reset_n(reset_n), .instrucao(instrucao), .instr_valida(instr_valida),
    .pc_mais4(pc_mais4), .descarte(descarte), .banco(banco.master),
    .uc_escrita_wb(uc_escrita_wb), .endereco_escrita_wb(endereco_escrita_wb),
    .dado_escrita_wb(dado_escrita_wb), .parar_if(parar_if), .ex_valido(ex_valido),
    .ex_reg_escrita(ex_reg_escrita), .ex_mem_leitura(ex_mem_leitura),
    .ex_mem_escrita(ex_mem_escrita), .ex_mem_para_reg(ex_mem_para_reg),
    .ex_ula_fonte(ex_ula_fonte), .ex_excecao(ex_excecao), .ex_ula_op(ex_ula_op),
    .ex_dado_rs(ex_dado_rs), .ex_dado_rt(ex_dado_rt), .ex_imediato(ex_imediato),
    .ex_pc_mais4(ex_pc_mais4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_destino(ex_destino)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic valido, reg_escrita, mem_leitura, mem_escrita, mem_para_reg, ula_fonte, excecao;
    logic [3:0]  ula_op;
    logic [31:0] dado_rs, dado_rt, imediato, pc;
    logic [4:0]  rs, rt, destino;
  } esp_t;

  localparam logic [31:0] LW_T1     = 32'h8D090000;
  localparam logic [31:0] ADD_DEP   = 32'h01285020;
  localparam logic [31:0] ADD_INDEP = 32'h016C5020;

  int   checks, falhas;
  esp_t esp, esp_prox;
  logic esp_parar;
  logic [5:0] tab_op [0:9] = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04};
  logic [5:0] tab_fn [0:4] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  function automatic logic [31:0] fonte(input logic [4:0] a, input logic [31:0] banco_d,
                                        input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
    if (a == 5'd0) return 32'd0;
    if (wbe && wba == a) return wbd;
    return banco_d;
  endfunction

  // Reference decode straight from the ISA table.
  function automatic esp_t modelo(input logic [31:0] ins, d1, d2, pc,
                                  input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
    esp_t e;
    logic [15:0] im;
    e = '0;
    im = ins[15:0];
    e.valido = 1'b1;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    e.pc = pc;
    e.dado_rs = fonte(e.rs, d1, wbe, wba, wbd);
    e.dado_rt = fonte(e.rt, d2, wbe, wba, wbd);
    e.imediato = {{16{im[15]}}, im};
    e.destino = e.rt;
    case (ins[31:26])
      6'h00: begin
        e.destino = ins[15:11];
        e.reg_escrita = 1'b1;
        case (ins[5:0])
          6'h20: e.ula_op = 4'd0;
          6'h22: e.ula_op = 4'd1;
          6'h24: e.ula_op = 4'd2;
          6'h25: e.ula_op = 4'd3;
          6'h2A: e.ula_op = 4'd4;
          default: begin e.excecao = 1'b1; e.reg_escrita = 1'b0; end
        endcase
      end
      6'h08: begin e.reg_escrita = 1'b1; e.ula_fonte = 1'b1; e.ula_op = 4'd0; end
      6'h0A: begin e.reg_escrita = 1'b1; e.ula_fonte = 1'b1; e.ula_op = 4'd4; end
      6'h0C: begin e.reg_escrita = 1'b1; e.ula_fonte = 1'b1; e.ula_op = 4'd2; e.imediato = {16'h0, im}; end
      6'h0D: begin e.reg_escrita = 1'b1; e.ula_fonte = 1'b1; e.ula_op = 4'd3; e.imediato = {16'h0, im}; end
      6'h0F: begin e.reg_escrita = 1'b1; e.ula_fonte = 1'b1; e.ula_op = 4'd5; e.imediato = {im, 16'h0}; end
      6'h23: begin e.reg_escrita = 1'b1; e.ula_fonte = 1'b1; e.mem_leitura = 1'b1; e.mem_para_reg = 1'b1; end
      6'h2B: begin e.ula_fonte = 1'b1; e.mem_escrita = 1'b1; end
      6'h04: e.ula_op = 4'd1;
      default: e.excecao = 1'b1;
    endcase
    if (e.destino == 5'd0) e.reg_escrita = 1'b0;
    return e;
  endfunction

  // Fields left undefined for illegal instructions are masked out of the comparison.
  function automatic logic [153:0] vet(input esp_t e, input logic mascara);
    return {e.valido, e.reg_escrita, e.mem_leitura, e.mem_escrita, e.mem_para_reg,
            mascara ? 1'b0 : e.ula_fonte, e.excecao, mascara ? 4'h0 : e.ula_op,
            e.dado_rs, e.dado_rt, mascara ? 32'h0 : e.imediato, e.pc,
            e.rs, e.rt, mascara ? 5'h0 : e.destino};
  endfunction

  function automatic esp_t observado();
    esp_t o;
    o = {ex_valido, ex_reg_escrita, ex_mem_leitura, ex_mem_escrita, ex_mem_para_reg,
         ex_ula_fonte, ex_excecao, ex_ula_op, ex_dado_rs, ex_dado_rt, ex_imediato,
         ex_pc_mais4, ex_rs, ex_rt, ex_destino};
    return o;
  endfunction

  // Drive one IF/ID slot at the falling edge and predict stall and next ID/EX.
  task automatic dirigir(input logic [31:0] ins, input logic val, desc,
                         input logic [31:0] d1, d2, input logic wbe,
                         input logic [4:0] wba, input logic [31:0] wbd);
    logic risco, usa_rt;
    @(negedge clock);
    instrucao = ins; instr_valida = val; descarte = desc;
    banco.dado_leitura_1 = d1; banco.dado_leitura_2 = d2;
    uc_escrita_wb = wbe; endereco_escrita_wb = wba; dado_escrita_wb = wbd;
    pc_mais4 = $urandom;
    #1;
    usa_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
    risco = esp.valido && esp.mem_leitura && esp.destino != 5'd0 && val &&
            (esp.destino == ins[25:21] || (usa_rt && esp.destino == ins[20:16]));
    esp_parar = risco && !desc;
    esp_prox = (!val || desc || risco) ? esp_t'(0) : modelo(ins, d1, d2, pc_mais4, wbe, wba, wbd);
  endtask

  task automatic avancar();
    @(posedge clock);
    #1;
    esp = esp_prox;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dirigir(LW_T1, 1'b1, 1'b0, 32'h1111, 32'h2222, 1'b0, 5'd0, 32'd0);
    esp = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      checks++;
      if (vet(observado(), 1'b0) !== 154'd0) begin
        falhas++; $display("FAIL reset_ex got=%h exp=0", vet(observado(), 1'b0));
      end
      checks++;
      if (parar_if !== 1'b0) begin falhas++; $display("FAIL reset_parar got=%b exp=0", parar_if); end
    end
    #1 reset_n = 1'b1;
    #1;
    checks++;
    if (ex_valido !== 1'b0) begin falhas++; $display("FAIL reset_release got=%b exp=0", ex_valido); end
    dirigir(LW_T1, 1'b1, 1'b0, 32'h1111, 32'h2222, 1'b0, 5'd0, 32'd0);
    avancar();
    checks++;
    if (ex_valido !== 1'b1 || ex_mem_leitura !== 1'b1 || ex_destino !== 5'd9 || ex_dado_rs !== 32'h1111) begin
      falhas++; $display("FAIL reset_first_lw got=%b%b/%0d/%h exp=11/9/00001111",
                         ex_valido, ex_mem_leitura, ex_destino, ex_dado_rs);
    end
  endtask

  task automatic test_addi_zero();
    dirigir(32'h2008FFFB, 1'b1, 1'b0, 32'h1234, 32'h5678, 1'b0, 5'd0, 32'd0);
    avancar();
    checks++;
    if (ex_imediato !== 32'hFFFFFFFB || ex_destino !== 5'd8 || ex_ula_fonte !== 1'b1 ||
        ex_dado_rs !== 32'd0 || ex_reg_escrita !== 1'b1) begin
      falhas++; $display("FAIL addi got imm=%h dst=%0d src=%b rs=%h we=%b exp=fffffffb/8/1/0/1",
                         ex_imediato, ex_destino, ex_ula_fonte, ex_dado_rs, ex_reg_escrita);
    end
  endtask

  task automatic test_load_use();
    dirigir(LW_T1, 1'b1, 1'b0, 32'h10, 32'h20, 1'b0, 5'd0, 32'd0);
    avancar();
    dirigir(ADD_DEP, 1'b1, 1'b0, 32'h30, 32'h40, 1'b0, 5'd0, 32'd0);
    checks++;
    if (parar_if !== 1'b1) begin falhas++; $display("FAIL lu_stall got=%b exp=1", parar_if); end
    avancar();
    checks++;
    if (vet(observado(), 1'b0) !== 154'd0) begin
      falhas++; $display("FAIL lu_bubble got=%h exp=0", vet(observado(), 1'b0));
    end
    dirigir(ADD_DEP, 1'b1, 1'b0, 32'h30, 32'h40, 1'b0, 5'd0, 32'd0);
    checks++;
    if (parar_if !== 1'b0) begin falhas++; $display("FAIL lu_release got=%b exp=0", parar_if); end
    avancar();
    checks++;
    if (ex_valido !== 1'b1 || ex_rs !== 5'd9 || ex_destino !== 5'd10 || ex_dado_rs !== 32'h30) begin
      falhas++; $display("FAIL lu_add got v=%b rs=%0d dst=%0d d=%h exp=1/9/10/30",
                         ex_valido, ex_rs, ex_destino, ex_dado_rs);
    end
    dirigir(LW_T1, 1'b1, 1'b0, 32'h10, 32'h20, 1'b0, 5'd0, 32'd0);
    avancar();
    dirigir(ADD_INDEP, 1'b1, 1'b0, 32'h50, 32'h60, 1'b0, 5'd0, 32'd0);
    checks++;
    if (parar_if !== 1'b0) begin falhas++; $display("FAIL lu_indep got=%b exp=0", parar_if); end
    avancar();
    checks++;
    if (ex_valido !== 1'b1 || ex_rs !== 5'd11 || ex_rt !== 5'd12) begin
      falhas++; $display("FAIL lu_indep_load got v=%b rs=%0d rt=%0d exp=1/11/12", ex_valido, ex_rs, ex_rt);
    end
  endtask

  task automatic test_bypass();
    dirigir(ADD_DEP, 1'b1, 1'b0, 32'd0, 32'h77, 1'b1, 5'd9, 32'hCAFEF00D);
    avancar();
    checks++;
    if (ex_dado_rs !== 32'hCAFEF00D || ex_dado_rt !== 32'h77) begin
      falhas++; $display("FAIL bypass_wb got rs=%h rt=%h exp=cafef00d/00000077", ex_dado_rs, ex_dado_rt);
    end
    dirigir(ADD_DEP, 1'b1, 1'b0, 32'h13572468, 32'h88, 1'b1, 5'd0, 32'hCAFEF00D);
    avancar();
    checks++;
    if (ex_dado_rs !== 32'h13572468) begin
      falhas++; $display("FAIL bypass_r0 got=%h exp=13572468", ex_dado_rs);
    end
  endtask

  task automatic test_descarte();
    dirigir(LW_T1, 1'b1, 1'b0, 32'h10, 32'h20, 1'b0, 5'd0, 32'd0);
    avancar();
    dirigir(ADD_DEP, 1'b1, 1'b1, 32'h30, 32'h40, 1'b0, 5'd0, 32'd0);
    checks++;
    if (parar_if !== 1'b0) begin falhas++; $display("FAIL desc_parar got=%b exp=0", parar_if); end
    avancar();
    checks++;
    if (ex_valido !== 1'b0 || ex_reg_escrita !== 1'b0) begin
      falhas++; $display("FAIL desc_bubble got=%b%b exp=00", ex_valido, ex_reg_escrita);
    end
    dirigir(ADD_DEP, 1'b1, 1'b0, 32'h30, 32'h40, 1'b0, 5'd0, 32'd0);
    checks++;
    if (parar_if !== 1'b0) begin falhas++; $display("FAIL desc_next_parar got=%b exp=0", parar_if); end
    avancar();
    checks++;
    if (ex_valido !== 1'b1 || ex_rs !== 5'd9) begin
      falhas++; $display("FAIL desc_next got v=%b rs=%0d exp=1/9", ex_valido, ex_rs);
    end
  endtask

  task automatic test_invalida();
    dirigir(LW_T1, 1'b1, 1'b0, 32'h10, 32'h20, 1'b0, 5'd0, 32'd0);
    avancar();
    dirigir(ADD_DEP, 1'b0, 1'b0, 32'h30, 32'h40, 1'b0, 5'd0, 32'd0);
    checks++;
    if (parar_if !== 1'b0) begin falhas++; $display("FAIL inval_parar got=%b exp=0", parar_if); end
    avancar();
    checks++;
    if (ex_valido !== 1'b0) begin falhas++; $display("FAIL inval_bubble got=%b exp=0", ex_valido); end
  endtask

  task automatic test_excecao();
    dirigir(32'hFC221234, 1'b1, 1'b0, 32'h5, 32'h6, 1'b0, 5'd0, 32'd0);
    avancar();
    checks++;
    if (ex_excecao !== 1'b1 || ex_valido !== 1'b1 || ex_reg_escrita !== 1'b0 ||
        ex_mem_escrita !== 1'b0 || ex_mem_leitura !== 1'b0 || ex_mem_para_reg !== 1'b0) begin
      falhas++; $display("FAIL excecao got exc=%b v=%b we=%b mw=%b mr=%b mtr=%b exp=1/1/0/0/0/0",
                         ex_excecao, ex_valido, ex_reg_escrita, ex_mem_escrita, ex_mem_leitura, ex_mem_para_reg);
    end
  endtask

  task automatic test_reset_parada();
    dirigir(LW_T1, 1'b1, 1'b0, 32'h10, 32'h20, 1'b0, 5'd0, 32'd0);
    avancar();
    dirigir(ADD_DEP, 1'b1, 1'b0, 32'h30, 32'h40, 1'b0, 5'd0, 32'd0);
    checks++;
    if (parar_if !== 1'b1) begin falhas++; $display("FAIL rstmid_pre got=%b exp=1", parar_if); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (ex_valido !== 1'b0 || ex_mem_leitura !== 1'b0 || parar_if !== 1'b0) begin
      falhas++; $display("FAIL rstmid got v=%b mr=%b parar=%b exp=0/0/0", ex_valido, ex_mem_leitura, parar_if);
    end
    esp = '0;
    esp_prox = '0;
    esp_parar = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_aleatorio();
    logic [31:0] ins;
    logic [5:0]  op, fn;
    ins = ADD_INDEP;
    for (int c = 0; c < 400; c++) begin
      if (!esp_parar) begin
        op = (c % 13 == 12) ? 6'($urandom) : tab_op[$urandom_range(0, 9)];
        fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : tab_fn[$urandom_range(0, 4)];
        ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom), fn};
      end
      dirigir(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), $urandom, $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      checks++;
      if (parar_if !== esp_parar || banco.endereco_leitura_1 !== ins[25:21] ||
          banco.endereco_leitura_2 !== ins[20:16]) begin
        falhas++; $display("FAIL rand_comb c=%0d got parar=%b a1=%0d a2=%0d exp=%b/%0d/%0d",
                           c, parar_if, banco.endereco_leitura_1, banco.endereco_leitura_2,
                           esp_parar, ins[25:21], ins[20:16]);
      end
      avancar();
      checks++;
      if (vet(observado(), esp.excecao) !== vet(esp, esp.excecao)) begin
        falhas++; $display("FAIL rand_idex c=%0d got=%h exp=%h", c,
                           vet(observado(), esp.excecao), vet(esp, esp.excecao));
      end
    end
  endtask

  initial begin
    checks = 0; falhas = 0;
    clock = 1'b0; reset_n = 1'b0;
    instrucao = '0; instr_valida = 1'b0; pc_mais4 = '0; descarte = 1'b0;
    uc_escrita_wb = 1'b0; endereco_escrita_wb = '0; dado_escrita_wb = '0;
    banco.dado_leitura_1 = '0; banco.dado_leitura_2 = '0;
    esp = '0; esp_prox = '0; esp_parar = 1'b0;
    test_reset();
    test_addi_zero();
    test_load_use();
    test_bypass();
    test_descarte();
    test_invalida();
    test_excecao();
    test_reset_parada();
    test_aleatorio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, falhas);
    $finish;
  end

endmodule
